sram_stream_reader: RTL and testbench

//  Avalon-MM master that reads a block of words from the on-chip SRAM slave and

---
 rtl/sram_stream_reader_pkg.sv | 5 +
 rtl/sram_stream_reader_if.sv | 31 +++
 rtl/sram_stream_fifo.sv | 39 +++
 rtl/sram_stream_reader.sv | 109 ++++++++++
 tb/tb_sram_stream_reader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared types for the SRAM-to-stream reader: FSM encoding and bus constants.
package sram_stream_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;
endpackage

// File: rtl/sram_stream_reader_if.sv
// Avalon-MM read master bus plus Avalon-ST source bus of the SRAM stream reader.
interface sram_stream_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;

  modport master (
    output avm_address, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready
  );
endinterface

// File: rtl/sram_stream_fifo.sv
// Synchronous show-ahead FIFO; rdata always presents the head entry.
module sram_stream_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/sram_stream_reader.sv
// Reads a block of SRAM words with pipelined Avalon-MM reads and emits it as
// one Avalon-ST packet; a credit check keeps in-flight reads within FIFO space.
module sram_stream_reader
  import sram_stream_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  sram_stream_reader_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, issued, rcvd, popped, last_idx;
  logic [CNT_W-1:0]  outstanding, out_nxt, fifo_count, cnt_nxt;
  logic [CNT_W:0]    credit_used;
  logic              rd_q, rd_nxt;
  logic              accept, rdv_ok, pop, fifo_empty;
  logic [DATA_W+1:0] fifo_rdata;

  assign last_idx = len_q - LEN_W'(1);
  assign accept   = rd_q & ~bus.avm_waitrequest;
  // Returns with nothing outstanding belong to a job killed by reset.
  assign rdv_ok   = bus.avm_readdatavalid & (outstanding != '0);
  assign pop      = ~fifo_empty & bus.st_ready;

  always_comb begin
    out_nxt   = outstanding + CNT_W'(accept) - CNT_W'(rdv_ok);
    cnt_nxt   = fifo_count + CNT_W'(rdv_ok) - CNT_W'(pop);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FINISH : ISSUE;
      ISSUE:   if (accept && issued == last_idx) state_nxt = DRAIN;
      DRAIN:   if (pop && popped == last_idx) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Credit is evaluated on next-cycle occupancy so avm_read can be a flop;
    // occupancy never rises without an accept, so a raised read stays up.
    credit_used = {1'b0, out_nxt} + {1'b0, cnt_nxt};
    rd_nxt      = (state_nxt == ISSUE) && (credit_used < CREDITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued      <= '0;
      rcvd        <= '0;
      popped      <= '0;
      outstanding <= '0;
      rd_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_q        <= rd_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == FINISH);
      outstanding <= out_nxt;
      if (state == IDLE && start) begin
        addr_q <= start_addr;
        len_q  <= length;
        issued <= '0;
        rcvd   <= '0;
        popped <= '0;
      end else begin
        if (accept) begin
          addr_q <= addr_q + ADDR_W'(1);
          issued <= issued + LEN_W'(1);
        end
        if (rdv_ok) rcvd   <= rcvd + LEN_W'(1);
        if (pop)    popped <= popped + LEN_W'(1);
      end
    end
  end

  // Packet framing is tagged on arrival so the FIFO output is self-describing.
  sram_stream_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rdv_ok),
    .wdata ({rcvd == '0, rcvd == last_idx, bus.avm_readdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_byteenable = BYTEEN_ALL;
  assign bus.st_valid       = ~fifo_empty;
  assign bus.st_sop         = fifo_rdata[DATA_W+1];
  assign bus.st_eop         = fifo_rdata[DATA_W];
  assign bus.st_data        = fifo_rdata[DATA_W-1:0];
endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a fixed-latency SRAM slave model.
module tb_sram_stream_reader;
  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    int          c;
  } beat_t;

  logic        clk, reset, start, busy, done;
  logic [11:0] start_addr;
  logic [11:0] length;
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  int          lat;
  int          wr_lo, wr_hi, rl_lo, rl_hi;
  logic        no_valid;
  beat_t       beats[$];
  logic [11:0] addrs[$];
  int          dones[$];
  int          nacc, npop, max_infl;
  logic        acc_p [4];
  logic [11:0] adr_p [4];
  logic        p_wait, p_bp, p_sop, p_eop;
  logic [11:0] p_addr;
  logic [31:0] p_data;
  int          c0;

  sram_stream_reader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  sram_stream_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  function automatic logic [31:0] dat(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM slave: returns data for an accepted read 'lat' cycles later.
  always @(posedge clk) begin
    acc_p[0] <= bus.avm_read & ~bus.avm_waitrequest;
    adr_p[0] <= bus.avm_address;
    for (int i = 1; i < 4; i++) begin
      acc_p[i] <= acc_p[i-1];
      adr_p[i] <= adr_p[i-1];
    end
  end
  assign bus.avm_readdatavalid = acc_p[lat-1];
  assign bus.avm_readdata      = dat(adr_p[lat-1]);

  // Windowed waitrequest / backpressure driver.
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.st_ready        = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.avm_waitrequest = (cyc >= wr_lo) && (cyc <= wr_hi);
      bus.st_ready        = !((cyc >= rl_lo) && (cyc <= rl_hi));
    end
  end

  // Monitor: record bus transfers and check hold rules mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.avm_read && !bus.avm_waitrequest) begin
        addrs.push_back(bus.avm_address);
        nacc++;
      end
      if (bus.st_valid && bus.st_ready) begin
        beats.push_back('{bus.st_data, bus.st_sop, bus.st_eop, cyc});
        npop++;
      end
      if (nacc - npop > max_infl) max_infl = nacc - npop;
      if (done) dones.push_back(cyc);
      if (p_wait) begin
        chk("wr_hold_read", 32'(bus.avm_read), 32'd1);
        chk("wr_hold_addr", 32'(bus.avm_address), 32'(p_addr));
      end
      if (p_bp) begin
        chk("bp_hold_valid", 32'(bus.st_valid), 32'd1);
        chk("bp_hold_data", bus.st_data, p_data);
        chk("bp_hold_sop", 32'(bus.st_sop), 32'(p_sop));
        chk("bp_hold_eop", 32'(bus.st_eop), 32'(p_eop));
      end
      if (no_valid) chk("no_valid", 32'(bus.st_valid), 32'd0);
    end
    p_wait = !reset && bus.avm_read && bus.avm_waitrequest;
    p_addr = bus.avm_address;
    p_bp   = !reset && bus.st_valid && !bus.st_ready;
    p_data = bus.st_data;
    p_sop  = bus.st_sop;
    p_eop  = bus.st_eop;
  end

  task automatic run_job(input logic [11:0] a, input int len, output int c_start);
    int n;
    c_start = cyc;
    beats.delete();
    addrs.delete();
    dones.delete();
    nacc = 0;
    npop = 0;
    max_infl = 0;
    start      = 1'b1;
    start_addr = a;
    length     = 12'(len);
    step(1);
    start = 1'b0;
    chk("busy_t1", 32'(busy), 32'd1);
    chk("read_t1", 32'(bus.avm_read), 32'(len != 0));
    n = 0;
    while (dones.size() == 0 && n < 400) begin
      step(1);
      n++;
    end
    if (dones.size() == 0) chk("done_timeout", 32'd0, 32'd1);
    chk("n_done", 32'(dones.size()), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic verify(input logic [11:0] a, input int len);
    logic [11:0] ea;
    chk("n_addr", 32'(addrs.size()), 32'(len));
    chk("n_beat", 32'(beats.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      ea = a + 12'(i);
      if (i < addrs.size()) chk("addr", 32'(addrs[i]), 32'(ea));
      if (i < beats.size()) begin
        chk("data", beats[i].d, dat(ea));
        chk("sop", 32'(beats[i].sop), 32'(i == 0));
        chk("eop", 32'(beats[i].eop), 32'(i == len - 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    lat = 1;
    no_valid = 1'b0;
    wr_lo = 1; wr_hi = 0;
    rl_lo = 1; rl_hi = 0;
    nacc = 0; npop = 0; max_infl = 0;
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(bus.avm_read), 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_valid", 32'(bus.st_valid), 32'd0);
    chk("rst_sop", 32'(bus.st_sop), 32'd0);
    chk("rst_eop", 32'(bus.st_eop), 32'd0);
    chk("byteen", 32'(bus.avm_byteenable), 32'hF);
    reset = 1'b0;
    step(2);

    // 8 words, slave latency 1, no stalls: beats on c0+3..c0+10, done c0+11.
    run_job(12'h010, 8, c0);
    verify(12'h010, 8);
    for (int i = 0; i < beats.size(); i++) chk("b2b_cycle", 32'(beats[i].c), 32'(c0 + 3 + i));
    if (dones.size() > 0) chk("done_cycle", 32'(dones[0]), 32'(c0 + 11));
    step(2);

    // Empty job: done the cycle after start, nothing on either bus.
    run_job(12'h123, 0, c0);
    chk("len0_reads", 32'(addrs.size()), 32'd0);
    chk("len0_beats", 32'(beats.size()), 32'd0);
    if (dones.size() > 0) chk("len0_done_cycle", 32'(dones[0]), 32'(c0 + 1));
    step(2);

    // Second read (0x011) stalled for 3 cycles.
    wr_lo = cyc + 2; wr_hi = cyc + 4;
    run_job(12'h010, 8, c0);
    verify(12'h010, 8);
    wr_lo = 1; wr_hi = 0;
    step(2);

    // Sink stalls 10 cycles mid-packet; in-flight words cap at FIFO depth.
    rl_lo = cyc + 6; rl_hi = cyc + 15;
    run_job(12'h200, 16, c0);
    verify(12'h200, 16);
    chk("credit_max", 32'(max_infl), 32'd4);
    rl_lo = 1; rl_hi = 0;
    step(2);

    run_job(12'hFFE, 4, c0);
    verify(12'hFFE, 4);
    step(2);

    run_job(12'h3A5, 1, c0);
    verify(12'h3A5, 1);
    step(2);

    // Reset while draining with two reads still in flight (latency 3).
    lat = 3;
    step(2);
    c0 = cyc;
    dones.delete();
    start = 1'b1; start_addr = 12'h300; length = 12'd4;
    step(1);
    start = 1'b0;
    step(5);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(bus.st_valid), 32'd0);
    chk("midrst_read", 32'(bus.avm_read), 32'd0);
    reset = 1'b0;
    no_valid = 1'b1;
    step(6);
    no_valid = 1'b0;
    chk("midrst_no_done", 32'(dones.size()), 32'd0);
    lat = 1;
    step(2);
    run_job(12'h005, 1, c0);
    verify(12'h005, 1);

    step(2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
